// File: rtl/alu_pkg.sv
// Shared types and constants for the UART ALU packet parser.
// Covers opcodes, parser states, header/word sizes and the length type.
package alu_pkg;

   localparam int DATA_WIDTH   = 8;
   localparam int HEADER_BYTES = 4;
   localparam int WORD_BYTES   = 4;

   typedef logic [15:0] len_t;

   typedef enum logic [7:0] {
      OP_ADD  = 8'hA0,
      OP_AND  = 8'hA1,
      OP_ECHO = 8'hEC
   } opcode_e;

   typedef enum logic [2:0] {
      S_OPCODE,
      S_RSVD,
      S_LEN_LO,
      S_LEN_HI,
      S_ECHO,
      S_ACCUM,
      S_EMIT,
      S_DROP
   } state_e;

   function automatic logic isArithOp(input logic [7:0] op);
      return (op == OP_ADD) || (op == OP_AND);
   endfunction

endpackage

// File: rtl/alu_packet_parser_if.sv
// Byte-wide AXI-Stream link used on both sides of the packet parser.
interface alu_packet_parser_if;
   import alu_pkg::*;

   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;

   modport master (output tdata, output tvalid, input tready);
   modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/alu_word_accum.sv
// Assembles payload bytes LSB first into 32-bit operands and folds them
// into an ADD or AND accumulator; exposes one result byte at a time.
module alu_word_accum
   import alu_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       i_init,
   input  logic       i_isAnd,
   input  logic       i_clear,
   input  logic       i_byteValid,
   input  logic [7:0] i_byte,
   input  logic [1:0] i_sel,
   output logic [7:0] o_byte
);

   logic [31:0] r_op;
   logic [31:0] r_acc;
   logic [1:0]  r_byteCnt;
   logic        r_isAnd;
   logic [31:0] w_word;

   // New bytes shift in from the top, so after four bytes the first one sits in [7:0].
   assign w_word = {i_byte, r_op[31:8]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_op      <= '0;
         r_acc     <= '0;
         r_byteCnt <= '0;
         r_isAnd   <= 1'b0;
      end else if (i_clear) begin
         r_op      <= '0;
         r_acc     <= '0;
         r_byteCnt <= '0;
         r_isAnd   <= 1'b0;
      end else if (i_init) begin
         r_op      <= '0;
         r_acc     <= i_isAnd ? 32'hFFFF_FFFF : 32'h0000_0000;
         r_byteCnt <= '0;
         r_isAnd   <= i_isAnd;
      end else if (i_byteValid) begin
         r_op      <= w_word;
         r_byteCnt <= r_byteCnt + 2'd1;
         if (r_byteCnt == 2'(WORD_BYTES - 1)) begin
            r_acc <= r_isAnd ? (r_acc & w_word) : (r_acc + w_word);
         end
      end
   end

   always_comb begin
      o_byte = r_acc[7:0];
      case (i_sel)
         2'd0:    o_byte = r_acc[7:0];
         2'd1:    o_byte = r_acc[15:8];
         2'd2:    o_byte = r_acc[23:16];
         default: o_byte = r_acc[31:24];
      endcase
   end

endmodule

// File: rtl/alu_packet_parser.sv
// Command layer between uart_rx and uart_tx: parses framed packets and
// either echoes the payload or returns a 32-bit ADD/AND result LSB first.
module alu_packet_parser
   import alu_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   alu_packet_parser_if.slave  s_axis,
   alu_packet_parser_if.master m_axis,
   output logic                busy_o,
   output logic                err_o
);

   state_e                r_state;
   state_e                w_nextState;
   logic                  r_started;
   logic [7:0]            r_opcode;
   logic [7:0]            r_lenLo;
   len_t                  r_count;
   logic [DATA_WIDTH-1:0] r_mData;
   logic                  r_mValid;
   logic                  r_err;
   logic [1:0]            r_emitIdx;
   logic                  r_allLoaded;

   logic                  w_sReady;
   logic                  w_sHs;
   logic                  w_mHs;
   logic                  w_outFree;
   len_t                  w_len;
   len_t                  w_payload;
   logic                  w_lastByte;
   logic                  w_err;
   logic                  w_accInit;
   logic                  w_accClear;
   logic                  w_echoLoad;
   logic                  w_emitLoad;
   logic                  w_accByteValid;
   logic [7:0]            w_accByte;

   assign w_sHs      = s_axis.tvalid && w_sReady;
   assign w_mHs      = r_mValid && m_axis.tready;
   assign w_outFree  = !r_mValid || m_axis.tready;
   assign w_len      = {s_axis.tdata, r_lenLo};
   assign w_payload  = w_len - len_t'(HEADER_BYTES);
   assign w_lastByte = (r_count == 16'd1);

   assign w_echoLoad     = (r_state == S_ECHO) && w_sHs;
   assign w_accByteValid = (r_state == S_ACCUM) && w_sHs;
   assign w_emitLoad     = (r_state == S_EMIT) && !r_allLoaded && w_outFree;

   assign s_axis.tready = w_sReady;
   assign m_axis.tdata  = r_mData;
   assign m_axis.tvalid = r_mValid;
   assign busy_o        = (r_state != S_OPCODE);
   assign err_o         = r_err;

   // Holds tready low until the first edge after reset is released.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_started <= 1'b0;
         r_state   <= S_OPCODE;
         r_err     <= 1'b0;
      end else begin
         r_started <= 1'b1;
         r_state   <= w_nextState;
         r_err     <= w_err;
      end
   end

   always_comb begin
      w_nextState = r_state;
      w_sReady    = 1'b0;
      w_err       = 1'b0;
      w_accInit   = 1'b0;
      w_accClear  = 1'b0;
      case (r_state)
         S_OPCODE: begin
            w_sReady = r_started;
            if (w_sHs) w_nextState = S_RSVD;
         end
         S_RSVD: begin
            w_sReady = 1'b1;
            if (w_sHs) w_nextState = S_LEN_LO;
         end
         S_LEN_LO: begin
            w_sReady = 1'b1;
            if (w_sHs) w_nextState = S_LEN_HI;
         end
         S_LEN_HI: begin
            w_sReady = 1'b1;
            if (w_sHs) begin
               // Zero-length payloads skip straight past the payload states.
               if (w_len < len_t'(HEADER_BYTES)) begin
                  w_err       = 1'b1;
                  w_nextState = S_OPCODE;
               end else if (r_opcode == OP_ECHO) begin
                  w_nextState = (w_payload == '0) ? S_OPCODE : S_ECHO;
               end else if (isArithOp(r_opcode)) begin
                  w_accInit   = 1'b1;
                  w_nextState = (w_payload == '0) ? S_EMIT : S_ACCUM;
               end else begin
                  w_err       = 1'b1;
                  w_nextState = (w_payload == '0) ? S_OPCODE : S_DROP;
               end
            end
         end
         S_ECHO: begin
            w_sReady = w_outFree;
            if (w_sHs && w_lastByte) w_nextState = S_OPCODE;
         end
         S_ACCUM: begin
            w_sReady = 1'b1;
            if (w_sHs && w_lastByte) w_nextState = S_EMIT;
         end
         S_EMIT: begin
            if (r_allLoaded && w_mHs) begin
               w_accClear  = 1'b1;
               w_nextState = S_OPCODE;
            end
         end
         S_DROP: begin
            w_sReady = 1'b1;
            if (w_sHs && w_lastByte) w_nextState = S_OPCODE;
         end
         default: w_nextState = S_OPCODE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_opcode <= '0;
         r_lenLo  <= '0;
         r_count  <= '0;
      end else if (w_sHs) begin
         case (r_state)
            S_OPCODE: r_opcode <= s_axis.tdata;
            S_LEN_LO: r_lenLo  <= s_axis.tdata;
            S_LEN_HI: r_count  <= (w_len < len_t'(HEADER_BYTES)) ? '0 : w_payload;
            S_ECHO, S_ACCUM, S_DROP: r_count <= r_count - 16'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Single output register shared by echo bytes and result bytes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mData  <= '0;
         r_mValid <= 1'b0;
      end else if (w_echoLoad) begin
         r_mData  <= s_axis.tdata;
         r_mValid <= 1'b1;
      end else if (w_emitLoad) begin
         r_mData  <= w_accByte;
         r_mValid <= 1'b1;
      end else if (w_mHs) begin
         r_mValid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_emitIdx   <= '0;
         r_allLoaded <= 1'b0;
      end else if (w_accClear) begin
         r_emitIdx   <= '0;
         r_allLoaded <= 1'b0;
      end else if (w_emitLoad) begin
         r_emitIdx <= r_emitIdx + 2'd1;
         if (r_emitIdx == 2'd3) r_allLoaded <= 1'b1;
      end
   end

   alu_word_accum u_accum (
      .clk         (clk),
      .rst         (rst),
      .i_init      (w_accInit),
      .i_isAnd     (r_opcode == OP_AND),
      .i_clear     (w_accClear),
      .i_byteValid (w_accByteValid),
      .i_byte      (s_axis.tdata),
      .i_sel       (r_emitIdx),
      .o_byte      (w_accByte)
   );

endmodule

// File: tb/tb_alu_packet_parser.sv
// Directed bench for alu_packet_parser: drives packets byte by byte and
// compares every output byte against a queue of expected values.
module tb_alu_packet_parser;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       busy;
   logic       err;
   logic       sVld = 1'b0;
   logic [7:0] sData = 8'h00;
   logic       mRdyBase = 1'b1;
   logic       toggleEn = 1'b0;
   logic       toggleVal = 1'b1;
   int         togCnt = 0;

   int         checks = 0;
   int         errors = 0;
   int         outCount = 0;
   int         errRun = 0;
   int         errPulses = 0;
   int         errMaxRun = 0;
   logic       prevStall = 1'b0;
   logic [7:0] prevData = 8'h00;

   logic [7:0] expQ[$];
   logic [7:0] pkt[$];

   always #5 clk = ~clk;

   alu_packet_parser_if sIf();
   alu_packet_parser_if mIf();

   assign sIf.tvalid = sVld;
   assign sIf.tdata  = sData;
   assign mIf.tready = toggleEn ? toggleVal : mRdyBase;

   alu_packet_parser dut (
      .clk    (clk),
      .rst    (rst),
      .s_axis (sIf),
      .m_axis (mIf),
      .busy_o (busy),
      .err_o  (err)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Downstream readiness toggles every three cycles when enabled.
   always @(posedge clk) begin
      #1;
      togCnt++;
      if (togCnt == 3) begin
         togCnt    = 0;
         toggleVal = ~toggleVal;
      end
   end

   // Scoreboard side: every output handshake pops one expected byte.
   always @(negedge clk) begin
      if (rst) begin
         if (prevStall) begin
            checkOutput("stall_valid", 32'(mIf.tvalid), 32'd1);
            checkOutput("stall_data", 32'(mIf.tdata), 32'(prevData));
         end
         if (mIf.tvalid && mIf.tready) begin
            outCount++;
            checks++;
            assert (expQ.size() > 0) else begin
               errors++;
               $error("[TB] FAIL out_unexpected observed %0h expected none", mIf.tdata);
            end
            if (expQ.size() > 0) checkOutput("out_byte", 32'(mIf.tdata), 32'(expQ.pop_front()));
         end
         prevStall = mIf.tvalid && !mIf.tready;
         prevData  = mIf.tdata;
      end else begin
         prevStall = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         errRun = 0;
      end else if (err) begin
         errRun++;
      end else if (errRun > 0) begin
         errPulses++;
         if (errRun > errMaxRun) errMaxRun = errRun;
         errRun = 0;
      end
   end

   task automatic sendByte(input logic [7:0] b);
      logic hs;
      int   n;
      n     = 0;
      sVld  = 1'b1;
      sData = b;
      forever begin
         @(negedge clk);
         hs = sIf.tready;
         @(posedge clk);
         #1;
         if (hs) break;
         n++;
         if (n > 200) begin
            checks++;
            errors++;
            $error("[TB] FAIL send_timeout observed stalled expected accept of %0h", b);
            break;
         end
      end
   endtask

   task automatic applyStimulus();
      @(posedge clk);
      #1;
      foreach (pkt[i]) sendByte(pkt[i]);
      sVld = 1'b0;
   endtask

   task automatic waitDrain(input string tag);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (expQ.size() == 0 && !mIf.tvalid && !busy) break;
      end
      checkOutput({tag, "_pending"}, 32'(expQ.size()), 32'd0);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int errBefore;
      int outBefore;

      #12;
      checkOutput("rst_mvalid", 32'(mIf.tvalid), 32'd0);
      checkOutput("rst_mdata", 32'(mIf.tdata), 32'd0);
      checkOutput("rst_sready", 32'(sIf.tready), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_err", 32'(err), 32'd0);
      #11 rst = 1'b1;
      #1 checkOutput("rel_sready_pre", 32'(sIf.tready), 32'd0);
      @(posedge clk);
      #1 checkOutput("rel_sready_post", 32'(sIf.tready), 32'd1);

      pkt = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43};
      expQ.push_back(8'h41); expQ.push_back(8'h42); expQ.push_back(8'h43);
      applyStimulus();
      waitDrain("echo");

      pkt = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
              8'hFF, 8'hFF, 8'hFF, 8'hFF};
      repeat (4) expQ.push_back(8'h00);
      applyStimulus();
      waitDrain("add_wrap");

      pkt = '{8'hA1, 8'h00, 8'h0A, 8'h00, 8'hF0, 8'hFF, 8'h00, 8'hFF, 8'hAA, 8'hBB};
      expQ.push_back(8'hF0); expQ.push_back(8'hFF); expQ.push_back(8'h00); expQ.push_back(8'hFF);
      applyStimulus();
      waitDrain("and_trail");

      errBefore = errPulses;
      outBefore = outCount;
      pkt = '{8'h55, 8'h00, 8'h06, 8'h00, 8'h11, 8'h22};
      applyStimulus();
      waitDrain("unknown");
      repeat (3) @(negedge clk);
      checkOutput("unknown_err_pulses", 32'(errPulses - errBefore), 32'd1);
      checkOutput("unknown_no_output", 32'(outCount - outBefore), 32'd0);

      pkt = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h7E};
      expQ.push_back(8'h7E);
      applyStimulus();
      waitDrain("echo_after_err");

      pkt = '{8'hA1, 8'h00, 8'h04, 8'h00};
      repeat (4) expQ.push_back(8'hFF);
      applyStimulus();
      waitDrain("and_empty");

      errBefore = errPulses;
      outBefore = outCount;
      pkt = '{8'hEC, 8'h00, 8'h02, 8'h00};
      applyStimulus();
      waitDrain("short_len");
      repeat (3) @(negedge clk);
      checkOutput("short_err_pulses", 32'(errPulses - errBefore), 32'd1);
      checkOutput("short_no_output", 32'(outCount - outBefore), 32'd0);

      toggleEn = 1'b1;
      pkt = '{8'hEC, 8'h00, 8'h08, 8'h00, 8'hD1, 8'hD2, 8'hD3, 8'hD4};
      expQ.push_back(8'hD1); expQ.push_back(8'hD2); expQ.push_back(8'hD3); expQ.push_back(8'hD4);
      applyStimulus();
      waitDrain("backpressure");
      toggleEn = 1'b0;

      pkt = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h02};
      applyStimulus();
      rst = 1'b0;
      #1;
      checkOutput("midrst_mvalid", 32'(mIf.tvalid), 32'd0);
      checkOutput("midrst_mdata", 32'(mIf.tdata), 32'd0);
      checkOutput("midrst_sready", 32'(sIf.tready), 32'd0);
      checkOutput("midrst_busy", 32'(busy), 32'd0);
      checkOutput("midrst_err", 32'(err), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("midrst_hold_sready", 32'(sIf.tready), 32'd0);
      checkOutput("midrst_hold_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      pkt = '{8'hA0, 8'h00, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
      expQ.push_back(8'h05); expQ.push_back(8'h00); expQ.push_back(8'h00); expQ.push_back(8'h00);
      applyStimulus();
      waitDrain("add_after_rst");

      repeat (3) @(negedge clk);
      checkOutput("err_total", 32'(errPulses), 32'd2);
      checkOutput("err_width", 32'(errMaxRun), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_packet_parser.md
Name: alu_packet_parser

Overview:
- Command layer of the UART ALU top, between the uart_rx byte stream and the uart_tx byte stream.
- Consumes framed packets from the receiver over AXI-Stream, 8-bit beats: opcode, reserved byte, 16-bit length (LSB first), payload.
- Echo packets return their payload unchanged.
- Arithmetic packets return one 32-bit result as 4 bytes, LSB first.

Parameters:
- DATA_WIDTH, 8, stream byte width; only 8 is supported.
- OP_ECHO, 8'hEC, opcode: echo payload.
- OP_ADD, 8'hA0, opcode: wrapping 32-bit sum of all operands.
- OP_AND, 8'hA1, opcode: bitwise AND of all operands.

Ports:
- clk  input  1  single clock.
- rst  input  1  asynchronous, active-low reset.
- s_axis_tdata  input  DATA_WIDTH  byte from uart_rx.
- s_axis_tvalid  input  1  upstream byte valid.
- s_axis_tready  output  1  parser accepts byte.
- m_axis_tdata  output  DATA_WIDTH  byte to uart_tx.
- m_axis_tvalid  output  1  output byte valid.
- m_axis_tready  input  1  uart_tx accepts byte.
- busy_o  output  1  high whenever state is not S_OPCODE.
- err_o  output  1  one-cycle pulse on an unknown opcode or a length below 4.

Behaviour:
- Reset, asserted asynchronously when rst is low:
  - state = S_OPCODE; all counters and the accumulator are cleared.
  - m_axis_tvalid = 0, m_axis_tdata = 0, s_axis_tready = 0, busy_o = 0, err_o = 0.
  - s_axis_tready rises on the first clk edge after rst is released.
- Handshakes:
  - A beat transfers on a clk edge where valid && ready.
  - m_axis_tdata and m_axis_tvalid are registered.
  - Once m_axis_tvalid is asserted, m_axis_tvalid and m_axis_tdata are held until the handshake completes.
- Length field:
  - Counts total packet bytes, header included.
  - Payload count = len - 4, kept in a 16-bit down-counter.
- States and transitions:
  - S_OPCODE: tready = 1; latch the opcode -> S_RSVD.
  - S_RSVD: accept and ignore one byte -> S_LEN_LO.
  - S_LEN_LO: latch len[7:0] -> S_LEN_HI.
  - S_LEN_HI: latch len[15:8], then decode:
    - len < 4: pulse err_o -> S_OPCODE.
    - len == 4 and opcode is ECHO -> S_OPCODE.
    - Unknown opcode: pulse err_o -> S_DROP.
    - ECHO -> S_ECHO.
    - ADD or AND -> S_ACCUM. On entry the accumulator is loaded with 0 for ADD, 32'hFFFFFFFF for AND.
  - S_ECHO:
    - s_axis_tready = !m_axis_tvalid || m_axis_tready, a one-entry pipe with 1-cycle latency.
    - Each accepted byte is registered onto m_axis_tdata and decrements the counter.
    - The last byte -> S_OPCODE; the output register is still allowed to drain.
  - S_ACCUM:
    - tready = 1; bytes are assembled LSB first into a 32-bit operand register.
    - On every 4th byte the operand is combined with the accumulator: acc + op mod 2^32, or acc & op.
    - Trailing 1-3 bytes that do not complete a word are consumed and discarded.
    - When the counter reaches 0 -> S_EMIT.
  - S_EMIT:
    - tready = 0; present acc[7:0], [15:8], [23:16], [31:24] on four successive handshakes.
    - 2-bit byte index; after the 4th handshake -> S_OPCODE.
    - With zero operands the result is the initial value: 0 for ADD, FFFFFFFF for AND.
  - S_DROP: tready = 1; consume len-4 bytes with no output -> S_OPCODE.
- Boundaries:
  - A payload count of 65531 is legal.
  - Upstream stalls (tvalid low) hold every state indefinitely.
  - Downstream backpressure stalls S_ECHO and S_EMIT only.
  - Reset mid-packet discards the partial packet and any undelivered output byte.
  - Timeout and resync are not supported; the sender must send whole packets.

Decomposition:
- Package alu_pkg:
  - opcode enum with ECHO, ADD and AND;
  - state enum;
  - HEADER_BYTES = 4, WORD_BYTES = 4;
  - 16-bit length typedef.
- Natural sub-module: alu_word_accum, which holds:
  - the byte-to-word assembler;
  - the 32-bit accumulator, with init, combine and clear inputs;
  - the byte-select output used by S_EMIT.

Test Plan:
- Echo: send EC 00 07 00 41 42 43 with m_axis_tready = 1 -> output 41 42 43, then busy_o = 0.
- Add:
  - Send A0 00 0C 00 01 00 00 00 FF FF FF FF, a payload of 8 bytes holding words 1 and FFFFFFFF.
  - Required output: 00 00 00 00, the wrap-around case.
- AND with trailing bytes:
  - Send A1 00 0A 00 F0 FF 00 FF AA BB.
  - Required output: F0 FF 00 FF; the trailing AA BB bytes produce no output.
- Unknown opcode:
  - Send 55 00 06 00 11 22 -> err_o pulses exactly 1 cycle and there is no output.
  - Then send EC 00 05 00 7E -> output 7E.
- Backpressure: echo 4 bytes with m_axis_tready toggling every 3 cycles -> bytes arrive in order, none lost or duplicated, and data is stable while stalled.
- Reset mid-operation:
  - Assert rst low during S_ACCUM, after 2 payload bytes.
  - All outputs must be zero while reset is held.
  - After release, send A0 00 08 00 05 00 00 00 -> output 05 00 00 00.
